score_level_tracker: RTL and testbench

Consumes line-clear results from the field-cleaning stage (lines_cleared plus its level-held done flag) and maintains the game score, total cleared lines, level and gravity period. The score is held in BCD for direct display, and points are accumulated with a multi-cycle digit-serial BCD adder. Sits between the field-cleaning stage and the display/gravity-timer logic, and is cleared at game start.

---
 rtl/score_level_tracker.sv | 158 +++++++++++++++
 tb/tb_score_level_tracker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/score_level_tracker.sv
// Score, line and level bookkeeping for each line-clear result from the field-cleaning stage.
// Points are accumulated into a BCD score one digit per cycle, repeated (level+1) times.
module score_level_tracker #(
  parameter int SCORE_DIGITS    = 6,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15,
  parameter int BASE_FRAMES     = 48,
  parameter int FRAME_STEP      = 5,
  parameter int MIN_FRAMES      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      game_start,
  input  logic [3:0]                start_level,
  input  logic                      clear_done,
  input  logic [2:0]                lines_cleared,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [15:0]               lines_total,
  output logic [3:0]                level,
  output logic [5:0]                gravity_frames,
  output logic                      busy,
  output logic                      update_pulse
);

  localparam int IDX_W  = $clog2(SCORE_DIGITS);
  localparam int LCNT_W = $clog2(LINES_PER_LEVEL + 1);

  typedef enum logic [1:0] {IDLE, ADD, LINES, UPDATE} state_t;

  state_t             state;
  logic               done_q;
  logic [15:0]        base_bcd;
  logic [4:0]         rep;
  logic [IDX_W-1:0]   digit_idx;
  logic               carry;
  logic               sat;
  logic [2:0]         lines_left;
  logic [LCNT_W-1:0]  level_cnt;

  logic [3:0]         cur_digit;
  logic [3:0]         base_digit;
  logic [4:0]         dsum;
  logic [3:0]         dres;
  logic               dcarry;
  logic               level_inc;
  logic [3:0]         level_after_line;
  logic [3:0]         start_clamped;
  logic               event_valid;

  function automatic logic [5:0] gravity_of(input logic [3:0] lvl);
    int g;
    g = BASE_FRAMES - int'(lvl) * FRAME_STEP;
    if (g < MIN_FRAMES) g = MIN_FRAMES;
    return 6'(g);
  endfunction

  function automatic logic [15:0] base_points(input logic [2:0] n);
    case (n)
      3'd1:    return 16'h0040;
      3'd2:    return 16'h0100;
      3'd3:    return 16'h0300;
      default: return 16'h1200;
    endcase
  endfunction

  assign start_clamped = (start_level > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : start_level;
  assign event_valid   = clear_done && !done_q && (lines_cleared != 3'd0);

  // One BCD digit of score + base + carry per cycle; base only has four digits.
  always_comb begin
    cur_digit  = score_bcd[4*digit_idx +: 4];
    base_digit = 4'd0;
    if (digit_idx < 4) base_digit = base_bcd[4*digit_idx[1:0] +: 4];
    dsum   = {1'b0, cur_digit} + {1'b0, base_digit} + {4'd0, carry};
    dres   = dsum[3:0];
    dcarry = 1'b0;
    if (dsum > 5'd9) begin
      dres   = 4'(dsum - 5'd10);
      dcarry = 1'b1;
    end
  end

  assign level_inc        = (level_cnt == LCNT_W'(LINES_PER_LEVEL - 1)) && (level != 4'(MAX_LEVEL));
  assign level_after_line = level_inc ? level + 4'd1 : level;

  always_ff @(posedge clk) begin
    if (rst || game_start) begin
      state          <= IDLE;
      done_q         <= 1'b0;
      score_bcd      <= '0;
      lines_total    <= 16'd0;
      level          <= rst ? 4'd0 : start_clamped;
      gravity_frames <= gravity_of(rst ? 4'd0 : start_clamped);
      busy           <= 1'b0;
      update_pulse   <= 1'b0;
      base_bcd       <= 16'd0;
      rep            <= 5'd0;
      digit_idx      <= '0;
      carry          <= 1'b0;
      sat            <= 1'b0;
      lines_left     <= 3'd0;
      level_cnt      <= '0;
    end else begin
      done_q <= clear_done;
      case (state)
        IDLE: begin
          if (event_valid) begin
            base_bcd   <= base_points(lines_cleared);
            lines_left <= (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
            rep        <= {1'b0, level} + 5'd1;
            digit_idx  <= '0;
            carry      <= 1'b0;
            busy       <= 1'b1;
            state      <= ADD;
          end
        end

        ADD: begin
          if (!sat) score_bcd[4*digit_idx +: 4] <= dres;
          carry     <= dcarry;
          digit_idx <= digit_idx + 1'b1;
          if (digit_idx == IDX_W'(SCORE_DIGITS - 1)) begin
            digit_idx <= '0;
            carry     <= 1'b0;
            // Overflow out of the top digit pins the score at all nines for the rest of the game.
            if (!sat && dcarry) begin
              sat       <= 1'b1;
              score_bcd <= {SCORE_DIGITS{4'h9}};
            end
            rep <= rep - 5'd1;
            if (rep == 5'd1) state <= LINES;
          end
        end

        LINES: begin
          if (lines_total != 16'hFFFF) lines_total <= lines_total + 16'd1;
          level_cnt  <= (level_cnt == LCNT_W'(LINES_PER_LEVEL - 1)) ? '0 : level_cnt + 1'b1;
          level      <= level_after_line;
          lines_left <= lines_left - 3'd1;
          if (lines_left == 3'd1) begin
            gravity_frames <= gravity_of(level_after_line);
            update_pulse   <= 1'b1;
            state          <= UPDATE;
          end
        end

        UPDATE: begin
          update_pulse <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_level_tracker.sv
// Directed bench for score_level_tracker with hand-computed scores, line counts and latencies.
module tb_score_level_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_start;
  logic [3:0]  start_level;
  logic        clear_done;
  logic [2:0]  lines_cleared;
  logic [23:0] score_bcd;
  logic [15:0] lines_total;
  logic [3:0]  level;
  logic [5:0]  gravity_frames;
  logic        busy;
  logic        update_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  score_level_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .game_start     (game_start),
    .start_level    (start_level),
    .clear_done     (clear_done),
    .lines_cleared  (lines_cleared),
    .score_bcd      (score_bcd),
    .lines_total    (lines_total),
    .level          (level),
    .gravity_frames (gravity_frames),
    .busy           (busy),
    .update_pulse   (update_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic startGame(input logic [3:0] lvl);
    game_start  = 1'b1;
    start_level = lvl;
    tick();
    game_start  = 1'b0;
  endtask

  // Raises clear_done, measures cycles from the edge cycle to update_pulse, then releases done.
  task automatic applyStimulus(input string tag, input logic [2:0] n, input int exp_lat);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    clear_done    = 1'b1;
    lines_cleared = n;
    while (k < 400 && !seen) begin
      tick();
      k++;
      seen = (update_pulse === 1'b1);
    end
    checkOutput({tag, "_latency"}, k, exp_lat);
    tick();
    checkOutput({tag, "_pulse_end"}, {30'd0, busy, update_pulse}, 32'd0);
    clear_done = 1'b0;
    tick();
  endtask

  initial begin
    int pulses;
    int busy_seen;

    rst           = 1'b1;
    game_start    = 1'b0;
    start_level   = 4'd0;
    clear_done    = 1'b0;
    lines_cleared = 3'd0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_score",   score_bcd, 24'h000000);
    checkOutput("rst_lines",   lines_total, 16'd0);
    checkOutput("rst_level",   level, 4'd0);
    checkOutput("rst_gravity", gravity_frames, 6'd48);
    checkOutput("rst_flags",   {busy, update_pulse}, 2'b00);

    applyStimulus("single", 3'd1, 8);
    checkOutput("single_score",   score_bcd, 24'h000040);
    checkOutput("single_lines",   lines_total, 16'd1);
    checkOutput("single_level",   level, 4'd0);
    checkOutput("single_gravity", gravity_frames, 6'd48);

    startGame(4'd2);
    checkOutput("gs2_score",   score_bcd, 24'h000000);
    checkOutput("gs2_level",   level, 4'd2);
    checkOutput("gs2_gravity", gravity_frames, 6'd38);
    applyStimulus("tetris_l2", 3'd4, 23);
    checkOutput("tetris_l2_score",   score_bcd, 24'h003600);
    checkOutput("tetris_l2_lines",   lines_total, 16'd4);
    checkOutput("tetris_l2_gravity", gravity_frames, 6'd38);

    startGame(4'd0);
    for (int i = 0; i < 9; i++) applyStimulus("lvlup_one", 3'd1, 8);
    checkOutput("lvlup_pre_score", score_bcd, 24'h000360);
    checkOutput("lvlup_pre_level", level, 4'd0);
    applyStimulus("lvlup_two", 3'd2, 9);
    checkOutput("lvlup_lines",   lines_total, 16'd11);
    checkOutput("lvlup_level",   level, 4'd1);
    checkOutput("lvlup_gravity", gravity_frames, 6'd43);
    checkOutput("lvlup_score",   score_bcd, 24'h000460);

    startGame(4'd15);
    checkOutput("sat_level0",   level, 4'd15);
    checkOutput("sat_gravity0", gravity_frames, 6'd2);
    for (int i = 0; i < 52; i++) applyStimulus("sat", 3'd4, 101);
    checkOutput("sat_score52", score_bcd, 24'h998400);
    applyStimulus("sat53", 3'd4, 101);
    checkOutput("sat_score53", score_bcd, 24'h999999);
    applyStimulus("sat54", 3'd4, 101);
    checkOutput("sat_score54", score_bcd, 24'h999999);
    checkOutput("sat_level",   level, 4'd15);
    checkOutput("sat_gravity", gravity_frames, 6'd2);
    checkOutput("sat_lines",   lines_total, 16'd216);

    startGame(4'd0);
    applyStimulus("abort_pre", 3'd1, 8);
    clear_done    = 1'b1;
    lines_cleared = 3'd3;
    tick();
    tick();
    tick();
    checkOutput("abort_busy_mid", busy, 1'b1);
    game_start  = 1'b1;
    start_level = 4'd0;
    clear_done  = 1'b0;
    tick();
    game_start = 1'b0;
    checkOutput("abort_score", score_bcd, 24'h000000);
    checkOutput("abort_lines", lines_total, 16'd0);
    checkOutput("abort_flags", {busy, update_pulse}, 2'b00);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (update_pulse === 1'b1) pulses++;
    end
    checkOutput("abort_no_pulse", pulses, 0);

    startGame(4'd0);
    clear_done    = 1'b1;
    lines_cleared = 3'd2;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (update_pulse === 1'b1) pulses++;
    end
    checkOutput("held_pulses", pulses, 1);
    clear_done = 1'b0;
    tick();
    checkOutput("held_score", score_bcd, 24'h000100);
    checkOutput("held_lines", lines_total, 16'd2);

    applyStimulus("clamp7", 3'd7, 11);
    checkOutput("clamp7_score", score_bcd, 24'h001300);
    checkOutput("clamp7_lines", lines_total, 16'd6);

    clear_done    = 1'b1;
    lines_cleared = 3'd0;
    pulses    = 0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (update_pulse === 1'b1) pulses++;
      if (busy === 1'b1) busy_seen++;
    end
    clear_done = 1'b0;
    tick();
    checkOutput("zero_pulses", pulses, 0);
    checkOutput("zero_busy",   busy_seen, 0);
    checkOutput("zero_score",  score_bcd, 24'h001300);
    checkOutput("zero_lines",  lines_total, 16'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
